muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and runs one radix-2 iteration per cycle. It raises `busy` so the hazard logic can stall any later instruction that needs HI/LO. It also supports a flush that aborts an in-flight operation on exception or eret.

## Interface
- `WIDTH`, 32: operand, HI and LO width.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width, derived; do not override.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command valid; sampled only in IDLE.
- `op`  in  3  command encoding from `muldiv_pkg`.
- `a`  in  WIDTH  rs operand (multiplicand/dividend/MTHI-MTLO data).
- `b`  in  WIDTH  rt operand (multiplier/divisor).
- `flush`  in  1  abort the current operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in flight; a new `start` is ignored.
- `done`  out  1  one-cycle pulse when HI/LO receive a mult/div result.
- `div_zero`  out  1  last completed divide had b==0; held until the next completed mult/div.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start` + MULT/MULTU/DIV/DIVU:
  - capture operands; for signed ops capture magnitudes and sign bits.
  - clear the counter; go to RUN.
- IDLE + `start` + MTHI/MTLO: write `a` to hi/lo at that edge; stay IDLE; `busy` and `done` stay 0.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle on unsigned magnitudes. After WIDTH steps go to FIX.
- FIX: apply sign correction, load hi/lo, pulse `done`, return to IDLE.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed product and quotient are negated when operand signs differ. The remainder takes the dividend's sign.
  - Most-negative ÷ −1 gives lo = most-negative (wraps) and hi = 0, with no flag.
- Divide by zero: runs the full latency; FIX writes lo = all ones, hi = a, `div_zero` = 1.
- `op` codes 6–7 in IDLE are ignored (no state change).
- `start` while `busy` is ignored. The pipeline must stall instead.

## Timing
- Reset (async, `reset`=0): state IDLE, hi=lo=0, busy=0, done=0, div_zero=0, counter 0. Takes effect immediately, including mid-operation.
- Mult/div latency: `start` sampled at edge E0.
  - RUN occupies edges E1..E_WIDTH.
  - FIX is applied at edge E_WIDTH+1.
  - `busy`=1 from after E0 until after E_WIDTH+1, i.e. WIDTH+1 cycles (33 for WIDTH=32).
  - New hi/lo and `done`=1 are visible in the cycle after E_WIDTH+1. `busy` is 0 in that same cycle.
- Back-to-back: a `start` in the `done` cycle is accepted.
- MTHI/MTLO: result visible after 1 edge.
- `flush`:
  - In RUN or FIX: next edge goes to IDLE. hi, lo and div_zero are unchanged, and there is no `done`.
  - With `start` in IDLE: flush wins and the command is dropped, MTHI/MTLO included.
- `done` never asserts for two consecutive cycles.
- Operands `a`/`b` may change freely after E0.

## Structure
- `muldiv_pkg`: op encodings OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5; state encodings ST_IDLE, ST_RUN, ST_FIX. The decoders and hazard unit include the same package.
- Sub-module `muldiv_core`: the WIDTH-bit unsigned iterate datapath (accumulator, shift register, single add/subtract with mode select). The FSM, counter, sign handling and HI/LO registers stay in `muldiv_unit`.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7:
  - busy high for 33 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFEB, with a single `done` pulse.
- MULTU a=b=0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7:
  - lo=14, hi=2.
- DIV −7/2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF:
  - lo=0x80000000, hi=0.
- DIV a=5, b=0:
  - after 33 cycles lo=0xFFFFFFFF, hi=5, div_zero=1.
  - A following MULTU 2×3 clears div_zero.
- MULT started, then:
  - `start`=1 with DIVU at cycle 5: ignored.
  - `flush` at cycle 10: busy=0 next cycle, hi/lo keep their prior values, no `done`.
- `reset`=0 mid-RUN, asynchronous to `clk`: hi, lo, busy, done and div_zero all read 0 before the next edge.
- MTHI a=0x12345678 in IDLE: hi=0x12345678 after one edge, busy never asserts.
- MTLO with simultaneous `flush`: lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit; also included by the decoders and hazard unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned radix-2 iterate datapath: shift-add multiply or restoring divide on one shared adder.
module muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mq
);

  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   lhs;
  logic [WIDTH:0]   rhs;
  logic [WIDTH:0]   res;
  logic             cin;

  // Divide subtracts via inverted operand plus carry-in; res[WIDTH] is then the borrow.
  always_comb begin
    lhs = {1'b0, acc};
    rhs = '0;
    cin = 1'b0;
    if (div_mode) begin
      lhs = {acc, mq[WIDTH-1]};
      rhs = ~{1'b0, opnd};
      cin = 1'b1;
    end else if (mq[0]) begin
      rhs = {1'b0, opnd};
    end
    res = lhs + rhs + (WIDTH+1)'(cin);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      mq   <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      mq   <= load_a;
      opnd <= load_b;
    end else if (step) begin
      if (div_mode) begin
        acc <= res[WIDTH] ? lhs[WIDTH-1:0] : res[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], ~res[WIDTH]};
      end else begin
        acc <= res[WIDTH:1];
        mq  <= {res[0], mq[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, busy stall and flush abort.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;

  logic             cap;
  logic             step;
  logic             fix;
  logic             wr_hi;
  logic             wr_lo;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && !flush && is_muldiv(op)) state_next = ST_RUN;
      ST_RUN:  if (flush) state_next = ST_IDLE;
               else if (cnt == LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control strobes; flush suppresses every update in the cycle it is seen
  always_comb begin
    cap   = 1'b0;
    step  = 1'b0;
    fix   = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    case (state)
      ST_IDLE: if (start && !flush) begin
        cap   = is_muldiv(op);
        wr_hi = (op == OP_MTHI);
        wr_lo = (op == OP_MTLO);
      end
      ST_RUN:  step = !flush;
      ST_FIX:  fix  = !flush;
      default: ;
    endcase
  end

  always_comb begin
    a_mag = (is_signed_op(op) && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed_op(op) && b[WIDTH-1]) ? -b : b;
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (cap),
    .step     (step),
    .div_mode (is_div),
    .load_a   (a_mag),
    .load_b   (b_mag),
    .acc      (acc),
    .mq       (mq)
  );

  // Sign fix-up; with b==0 the remainder path already reproduces a, only lo is forced
  always_comb begin
    prod = {acc, mq};
    if (sign_a ^ sign_b) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = sign_a ? -acc : acc;
      fix_lo = b_zero ? '1 : ((sign_a ^ sign_b) ? -mq : mq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= fix;
      if (cap) begin
        cnt    <= '0;
        is_div <= is_div_op(op);
        sign_a <= is_signed_op(op) && a[WIDTH-1];
        sign_b <= is_signed_op(op) && b[WIDTH-1];
        b_zero <= (b == '0);
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
      if (fix) begin
        hi       <= fix_hi;
        lo       <= fix_lo;
        div_zero <= is_div && b_zero;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO/div_zero, a monitor checks on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset && done) begin
      check("done_single_pulse", 64'(done_prev), 64'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        check("result_div_zero", 64'(div_zero), 64'(e.dz));
        check("busy_in_done_cycle", 64'(busy), 64'(0));
      end
    end
    done_prev = done;
  end

  // Issue one mult/div and measure busy length; b2b issues in the current (done) cycle
  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez,
                       input bit b2b);
    int n;
    if (!b2b) @(negedge clk);
    exp_q.push_back('{hi: eh, lo: el, dz: ez});
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_length", 64'(n), 64'(33));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = OP_MULT; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy_done_dz", 64'({busy, done, div_zero}), 64'(0));
    reset = 1'b1;

    do_op(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    do_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0);
    do_op(OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0);
    do_op(OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1'b0);
    do_op(OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 1'b1);
    do_op(OP_DIV,   32'hFFFFFFF6, 32'd0,        32'hFFFFFFF6, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Start while busy is ignored; flush aborts with HI/LO/div_zero intact
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored_start", 64'(busy), 64'(1));
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_hi", 64'(hi), 64'hFFFFFFF6);
    check("flush_lo", 64'(lo), 64'hFFFFFFFF);
    check("flush_div_zero", 64'(div_zero), 64'(1));
    repeat (40) @(negedge clk);
    check("flush_stays_idle", 64'(busy), 64'(0));

    start = 1'b1; op = OP_MTHI; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_lo_kept", 64'(lo), 64'hFFFFFFFF);
    check("mthi_busy_done", 64'({busy, done}), 64'(0));

    start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("mtlo_flush_lo", 64'(lo), 64'hFFFFFFFF);

    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_drops_mult", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of RUN
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_hi", 64'(hi), 64'(0));
    check("async_reset_lo", 64'(lo), 64'(0));
    check("async_reset_busy_done_dz", 64'({busy, done, div_zero}), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    do_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
